// File: rtl/mips_fetch_queue.sv
// rtl/mips_fetch_queue.sv - MIPS instruction-fetch front end with prefetch queue
// Owns the PC, issues in-order fetches under a credit limit and drops stale responses after redirect.
module mips_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] NOP      = '0
) (
   input  logic                     clock,
   input  logic                     rst_n,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [XLEN-1:0]          imem_req_addr,
   input  logic                     imem_rsp_valid,
   input  logic [XLEN-1:0]          imem_rsp_data,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   input  logic                     id_ready,
   output logic                     ifid_valid,
   output logic [XLEN-1:0]          ifid_ir,
   output logic [XLEN-1:0]          ifid_pc,
   output logic [XLEN-1:0]          ifid_pc4,
   output logic [$clog2(DEPTH):0]   queue_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

   state_t          state, state_nx;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] q_ir [DEPTH];
   logic [XLEN-1:0] q_pc [DEPTH];
   logic [AW-1:0]   rptr, wptr;
   logic [CW-1:0]   count, outstanding, discard;

   logic [CW:0]     credit_used;
   logic            accept, rsp_take, rsp_drop, push, pop;
   logic [CW-1:0]   discard_redir, discard_dec;
   logic [XLEN-1:0] rsp_pc;

   // In-flight fetches are always consecutive words ending just below pc.
   assign rsp_pc         = pc - (XLEN'(outstanding) << 2);
   assign credit_used    = {1'b0, outstanding} + {1'b0, count};
   assign imem_req_valid = (state == RUN) && (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;
   assign rsp_drop       = imem_rsp_valid && (discard != '0);
   assign rsp_take       = imem_rsp_valid && (discard == '0) && (outstanding != '0);
   assign push           = rsp_take && !redirect_valid;
   assign pop            = id_ready && ifid_valid && !redirect_valid;
   assign discard_redir  = outstanding + discard + CW'(accept) - CW'(rsp_take | rsp_drop);
   assign discard_dec    = discard - CW'(rsp_drop);

   assign ifid_valid  = (count != '0);
   assign ifid_ir     = ifid_valid ? q_ir[rptr] : NOP;
   assign ifid_pc     = ifid_valid ? q_pc[rptr] : rsp_pc;
   assign ifid_pc4    = ifid_pc + XLEN'(4);
   assign queue_count = count;

   always_comb begin
      state_nx = state;
      case (state)
         BOOT:    state_nx = RUN;
         RUN:     state_nx = RUN;
         DRAIN:   if (discard_dec == '0) state_nx = RUN;
         default: state_nx = BOOT;
      endcase
      if (redirect_valid) state_nx = (discard_redir != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         rptr        <= '0;
         wptr        <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         state <= state_nx;
         if (redirect_valid) begin
            pc          <= {redirect_pc[XLEN-1:2], 2'b00};
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= discard_redir;
         end else begin
            if (accept) pc <= pc + XLEN'(4);
            rptr        <= rptr + AW'(pop);
            wptr        <= wptr + AW'(push);
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
            discard     <= discard_dec;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         q_ir[wptr] <= imem_rsp_data;
         q_pc[wptr] <= rsp_pc;
      end
   end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb/tb_mips_fetch_queue.sv - directed bench for mips_fetch_queue
// Memory is a latency-programmable in-order responder driven from the step task.
module tb_mips_fetch_queue;

   logic        clock, rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        ifid_valid;
   logic [31:0] ifid_ir, ifid_pc, ifid_pc4;
   logic [2:0]  queue_count;

   int          n_chk, n_fail, cyc, lat, n_acc;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   logic        presented;

   mips_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(32'h0)) dut (
      .clock(clock), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_ready(id_ready),
      .ifid_valid(ifid_valid), .ifid_ir(ifid_ir), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
      .queue_count(queue_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: record acceptance at the edge, retire the consumed response, present the next due one.
   task automatic step();
      logic        acc;
      logic [31:0] a;
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clock);
      cyc++;
      #1;
      if (presented) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (acc) begin
         n_acc++;
         pend_addr.push_back(a);
         pend_due.push_back(cyc + lat);
      end
      presented = (pend_due.size() > 0) && (pend_due[0] <= cyc + 1);
      imem_rsp_valid = presented;
      imem_rsp_data  = presented ? word_at(pend_addr[0]) : 32'hDEAD_BEEF;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      imem_rsp_valid = 1'b0;
      presented      = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      n_acc = 0;
   endtask

   task automatic redirect_step(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; n_acc = 0; lat = 1;
      rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1; presented = 1'b0;
      #3;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
      check("rst_ifid_ir", ifid_ir, 32'h0);
      check("rst_ifid_pc", ifid_pc, 32'h0);
      check("rst_ifid_pc4", ifid_pc4, 32'h4);
      check("rst_count", 32'(queue_count), 32'd0);

      // 1: streaming with 1-cycle memory
      lat = 1; do_reset();
      step();
      check("t1_boot_req", 32'(imem_req_valid), 32'd1);
      check("t1_addr0", imem_req_addr, 32'h0);
      step();
      check("t1_addr4", imem_req_addr, 32'h4);
      check("t1_empty", 32'(ifid_valid), 32'd0);
      step();
      check("t1_valid", 32'(ifid_valid), 32'd1);
      check("t1_pc0", ifid_pc, 32'h0);
      check("t1_ir0", ifid_ir, word_at(32'h0));
      check("t1_addr8", imem_req_addr, 32'h8);
      step();
      check("t1_pc4", ifid_pc, 32'h4);
      step();
      check("t1_pc8", ifid_pc, 32'h8);
      check("t1_pc4out", ifid_pc4, 32'hC);
      check("t1_count", 32'(queue_count), 32'd1);

      // 2: stall fills the queue and throttles requests
      lat = 1; do_reset(); id_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("t2_count", 32'(queue_count), 32'd4);
      check("t2_req_valid", 32'(imem_req_valid), 32'd0);
      check("t2_n_req", 32'(n_acc), 32'd4);
      check("t2_pc_hold", ifid_pc, 32'h0);
      check("t2_ir_hold", ifid_ir, word_at(32'h0));
      id_ready = 1'b1;
      step();
      check("t2_pop_pc", ifid_pc, 32'h4);
      check("t2_pop_count", 32'(queue_count), 32'd3);

      // 3: latency 3, redirect with three fetches in flight
      lat = 3; do_reset();
      step(); step(); step();
      redirect_step(32'h40);
      check("t3_drain_req", 32'(imem_req_valid), 32'd0);
      check("t3_drain_addr", imem_req_addr, 32'h40);
      check("t3_flush", 32'(queue_count), 32'd0);
      step(); step();
      check("t3_still_drain", 32'(imem_req_valid), 32'd0);
      step();
      check("t3_run_req", 32'(imem_req_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_no_stale", 32'(ifid_valid), 32'd0);
      end
      step();
      check("t3_valid", 32'(ifid_valid), 32'd1);
      check("t3_pc", ifid_pc, 32'h40);
      check("t3_ir", ifid_ir, word_at(32'h40));

      // 4: redirect coincides with a response and an accepted request
      lat = 1; do_reset();
      step(); step();
      redirect_step(32'h80);
      check("t4_drain_req", 32'(imem_req_valid), 32'd0);
      check("t4_flush", 32'(ifid_valid), 32'd0);
      step();
      check("t4_run_req", 32'(imem_req_valid), 32'd1);
      check("t4_addr", imem_req_addr, 32'h80);
      step();
      check("t4_no_stale", 32'(ifid_valid), 32'd0);
      step();
      check("t4_pc", ifid_pc, 32'h80);
      check("t4_ir", ifid_ir, word_at(32'h80));

      // 5: unaligned target, then a second redirect while draining
      lat = 3; do_reset();
      step(); step();
      redirect_step(32'h103);
      check("t5_align", imem_req_addr, 32'h100);
      check("t5_drain_req", 32'(imem_req_valid), 32'd0);
      redirect_step(32'h200);
      check("t5_addr2", imem_req_addr, 32'h200);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_no_stale", 32'(ifid_valid), 32'd0);
      end
      step();
      check("t5_pc", ifid_pc, 32'h200);
      check("t5_ir", ifid_ir, word_at(32'h200));

      // 6: asynchronous reset with work queued and in flight
      lat = 3; do_reset(); id_ready = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("t6_pre_count", 32'(queue_count), 32'd3);
      rst_n = 1'b0;
      #1;
      check("t6_req_valid", 32'(imem_req_valid), 32'd0);
      check("t6_ifid_valid", 32'(ifid_valid), 32'd0);
      check("t6_ifid_ir", ifid_ir, 32'h0);
      check("t6_ifid_pc", ifid_pc, 32'h0);
      check("t6_count", 32'(queue_count), 32'd0);
      pend_addr.delete(); pend_due.delete(); presented = 1'b0;
      @(posedge clock); #1;
      rst_n = 1'b1;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
      step();
      check("t6_late_rsp", 32'(queue_count), 32'd0);
      check("t6_restart_addr", imem_req_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
